// File: rtl/barrel_regfile_if.sv
// rtl/barrel_regfile_if.sv - Writeback-write / decode-read port bundle for barrel_regfile
interface barrel_regfile_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_THREADS = 4
);
  localparam int BITS_THREADS = $clog2(NUM_THREADS);

  logic                    reg_write_w;
  logic [4:0]              rd_w;
  logic [BITS_THREADS-1:0] tid_w;
  logic [DATA_WIDTH-1:0]   result_w;
  logic [BITS_THREADS-1:0] tid_d;
  logic [4:0]              rs1_d;
  logic [4:0]              rs2_d;
  logic [DATA_WIDTH-1:0]   rd1_d;
  logic [DATA_WIDTH-1:0]   rd2_d;
  logic                    ready;

  modport master (
    output reg_write_w, rd_w, tid_w, result_w, tid_d, rs1_d, rs2_d,
    input  rd1_d, rd2_d, ready
  );

  modport slave (
    input  reg_write_w, rd_w, tid_w, result_w, tid_d, rs1_d, rs2_d,
    output rd1_d, rd2_d, ready
  );
endinterface

// File: rtl/barrel_regfile.sv
// rtl/barrel_regfile.sv - Per-thread register file with post-reset clear sequencer
// Optional same-cycle write-through forwarding enabled by defining RF_BYPASS_EN.
module barrel_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_THREADS = 4
) (
  input logic             clk,
  input logic             rst,
  barrel_regfile_if.slave bus
);
  localparam int BITS_THREADS = $clog2(NUM_THREADS);
  localparam int AW           = BITS_THREADS + 5;
  localparam int ENTRIES      = NUM_THREADS * 32;
  localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [AW-1:0]         clr_idx;
  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rs1_idx;
  logic [AW-1:0]         rs2_idx;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  assign wr_en   = (state == READY) && bus.reg_write_w && (bus.rd_w != 5'd0);
  assign wr_idx  = {bus.tid_w, bus.rd_w};
  assign rs1_idx = {bus.tid_d, bus.rs1_d};
  assign rs2_idx = {bus.tid_d, bus.rs2_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      bus.ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state     <= READY;
            bus.ready <= 1'b1;
          end
        end
        READY: ;
        default: state <= CLEAR;
      endcase
    end
  end

  // No reset on the array so it can map onto a RAM; the sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= bus.result_w;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (state == READY) begin
      if (bus.rs1_d != 5'd0) begin
        rd1 = mem[rs1_idx];
`ifdef RF_BYPASS_EN
        if (wr_en && (wr_idx == rs1_idx)) rd1 = bus.result_w;
`endif
      end
      if (bus.rs2_d != 5'd0) begin
        rd2 = mem[rs2_idx];
`ifdef RF_BYPASS_EN
        if (wr_en && (wr_idx == rs2_idx)) rd2 = bus.result_w;
`endif
      end
    end
  end

  assign bus.rd1_d = rd1;
  assign bus.rd2_d = rd2;
endmodule

// File: tb/tb_barrel_regfile.sv
// tb/tb_barrel_regfile.sv - Scoreboard bench for barrel_regfile against an array reference model
module tb_barrel_regfile;
  localparam int DW      = 32;
  localparam int NT      = 4;
  localparam int ENTRIES = NT * 32;

  typedef struct {
    logic          rdy;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    string         tag;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_pass;
  int   n_total;

  logic [DW-1:0] model [NT][32];
  int            m_cnt;

  barrel_regfile_if #(.DATA_WIDTH(DW), .NUM_THREADS(NT)) bus ();

  barrel_regfile #(.DATA_WIDTH(DW), .NUM_THREADS(NT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_read(input logic rdy, input logic we, input logic [4:0] rd,
                                             input logic [1:0] tw, input logic [DW-1:0] res,
                                             input logic [1:0] td, input logic [4:0] rs);
    if (!rdy || rs == 5'd0) return '0;
`ifdef RF_BYPASS_EN
    if (we && rd != 5'd0 && tw == td && rd == rs) return res;
`endif
    return model[td][rs];
  endfunction

  task automatic drive(input logic r, input logic we, input logic [4:0] rd, input logic [1:0] tw,
                       input logic [DW-1:0] res, input logic [1:0] td, input logic [4:0] r1,
                       input logic [4:0] r2, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = r;
    bus.reg_write_w = we;
    bus.rd_w        = rd;
    bus.tid_w       = tw;
    bus.result_w    = res;
    bus.tid_d       = td;
    bus.rs1_d       = r1;
    bus.rs2_d       = r2;
    e.tag = tag;
    if (r) begin
      m_cnt = 0;
      for (int t = 0; t < NT; t++)
        for (int i = 0; i < 32; i++) model[t][i] = '0;
      e.rdy = 1'b0;
      e.d1  = '0;
      e.d2  = '0;
    end else begin
      e.rdy = (m_cnt >= ENTRIES);
      e.d1  = ref_read(e.rdy, we, rd, tw, res, td, r1);
      e.d2  = ref_read(e.rdy, we, rd, tw, res, td, r2);
      if (e.rdy && we && rd != 5'd0) model[tw][rd] = res;
      if (m_cnt < ENTRIES) m_cnt++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_read(input logic [1:0] td, input logic [4:0] r1, input logic [4:0] r2, input string tag);
    drive(1'b0, 1'b0, 5'd0, 2'd0, '0, td, r1, r2, tag);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, " ready"}, {31'd0, bus.ready}, {31'd0, e.rdy});
      chk({e.tag, " rd1"}, bus.rd1_d, e.d1);
      chk({e.tag, " rd2"}, bus.rd2_d, e.d2);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    m_cnt = 0;
    rst = 1'b1;
    bus.reg_write_w = 1'b0;
    bus.rd_w = '0;
    bus.tid_w = '0;
    bus.result_w = '0;
    bus.tid_d = '0;
    bus.rs1_d = '0;
    bus.rs2_d = '0;

    drive(1'b1, 1'b0, 5'd0, 2'd0, '0, 2'd1, 5'd5, 5'd5, "reset");
    drive(1'b1, 1'b0, 5'd0, 2'd0, '0, 2'd2, 5'd5, 5'd7, "reset");

    // Clear sequence; a stray write lands at clear edge 10.
    for (int i = 0; i < ENTRIES + 2; i++) begin
      if (i == 10) drive(1'b0, 1'b1, 5'd4, 2'd0, 32'hFF, 2'(i), 5'd5, 5'd4, "clear_write");
      else idle_read(2'(i), 5'd5, 5'd4, "clear");
    end
    for (int t = 0; t < NT; t++) idle_read(2'(t), 5'd5, 5'd4, "post_clear");

    drive(1'b0, 1'b1, 5'd7, 2'd1, 32'hDEADBEEF, 2'd0, 5'd1, 5'd2, "iso_wr");
    idle_read(2'd1, 5'd7, 5'd7, "iso_t1");
    idle_read(2'd2, 5'd7, 5'd7, "iso_t2");

    drive(1'b0, 1'b1, 5'd0, 2'd3, 32'h12345678, 2'd3, 5'd0, 5'd0, "x0_wr");
    idle_read(2'd3, 5'd0, 5'd0, "x0_rd");

    drive(1'b0, 1'b1, 5'd10, 2'd0, 32'h1, 2'd1, 5'd10, 5'd10, "haz_init");
    drive(1'b0, 1'b1, 5'd10, 2'd0, 32'hA5A5A5A5, 2'd0, 5'd10, 5'd3, "haz_same");
    idle_read(2'd0, 5'd10, 5'd10, "haz_next");
    drive(1'b0, 1'b1, 5'd10, 2'd2, 32'h55, 2'd0, 5'd10, 5'd10, "haz_other_tid");

    for (int i = 0; i < 1500; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 2'($urandom),
            $urandom, 2'($urandom), 5'($urandom_range(0, 15)), 5'($urandom), "random");
    end

    drive(1'b0, 1'b1, 5'd7, 2'd1, 32'hCAFEF00D, 2'd1, 5'd7, 5'd0, "pre_rst_wr");
    idle_read(2'd1, 5'd7, 5'd7, "pre_rst_rd");
    drive(1'b1, 1'b0, 5'd0, 2'd0, '0, 2'd1, 5'd7, 5'd7, "rst_in_ready");
    for (int i = 0; i < 60; i++) idle_read(2'd1, 5'd7, 5'd7, "clear2");
    drive(1'b1, 1'b0, 5'd0, 2'd0, '0, 2'd1, 5'd7, 5'd7, "rst_mid_clear");
    for (int i = 0; i < ENTRIES + 3; i++) idle_read(2'd1, 5'd7, 5'd4, "clear3");

    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 2'($urandom),
            $urandom, 2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "random2");
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
